// File: rtl/adsr_envelope_generator.sv
// Four-stage ADSR envelope clocked by the audio sample tick, with a level gate and live rate/sustain inputs.
// Define ADSR_EXP_RELEASE_EN for an exponential release; otherwise the release is linear.
module adsr_envelope_generator #(
  parameter int GAIN_W        = 10,
  parameter int RATE_W        = 8,
  parameter int ATTACK_STEP   = 32,
  parameter int DECAY_STEP    = 16,
  parameter int RELEASE_STEP  = 32,
  parameter int RELEASE_SHIFT = 4
) (
  input  logic              audio_tick,
  input  logic              reset_n,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [RATE_W-1:0] release_rate,
  input  logic [GAIN_W-1:0] sustain_level,
  output logic [GAIN_W-1:0] gain,
  output logic              active,
  output logic [2:0]        env_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam logic [GAIN_W:0] MAX_EXT = (GAIN_W+1)'((1 << GAIN_W) - 1);
  localparam logic [GAIN_W:0] ATK_EXT = (GAIN_W+1)'(ATTACK_STEP);
  localparam logic [GAIN_W:0] DEC_EXT = (GAIN_W+1)'(DECAY_STEP);

  state_e              state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic [RATE_W-1:0]   div_q, div_d;
  logic                gate_prev_q;
  logic                active_q, active_d;

  logic                rise, fall, step;
  logic [RATE_W-1:0]   cur_rate;
  logic [GAIN_W:0]     gain_ext;

  assign rise     = gate & ~gate_prev_q;
  assign fall     = ~gate & gate_prev_q;
  assign gain_ext = {1'b0, gain_q};

`ifdef ADSR_EXP_RELEASE_EN
  logic [GAIN_W-1:0] exp_dec;
  // Shifted decrement never drops below 1 so the tail always reaches zero.
  always_comb begin
    exp_dec = gain_q >> RELEASE_SHIFT;
    if (exp_dec == '0) exp_dec = GAIN_W'(1);
  end
`endif

  always_comb begin
    cur_rate = '0;
    case (state_q)
      ATTACK:  cur_rate = attack_rate;
      DECAY:   cur_rate = decay_rate;
      RELEASE: cur_rate = release_rate;
      default: cur_rate = '0;
    endcase
    step = (div_q == cur_rate);
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    div_d   = step ? '0 : div_q + 1'b1;

    if (rise) begin
      // Retrigger keeps the current gain so the new attack starts without a click.
      state_d = ATTACK;
      div_d   = '0;
    end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
      div_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          gain_d = '0;
          div_d  = '0;
        end
        ATTACK: if (step) begin
          if (gain_ext + ATK_EXT >= MAX_EXT) begin
            gain_d  = MAX_EXT[GAIN_W-1:0];
            state_d = DECAY;
          end else begin
            gain_d = gain_q + GAIN_W'(ATTACK_STEP);
          end
        end
        DECAY: if (step) begin
          if (gain_ext <= {1'b0, sustain_level} + DEC_EXT) begin
            gain_d  = sustain_level;
            state_d = SUSTAIN;
          end else begin
            gain_d = gain_q - GAIN_W'(DECAY_STEP);
          end
        end
        SUSTAIN: begin
          gain_d = sustain_level;
          div_d  = '0;
        end
        RELEASE: if (step) begin
`ifdef ADSR_EXP_RELEASE_EN
          if (gain_q <= exp_dec) begin
            gain_d  = '0;
            state_d = IDLE;
          end else begin
            gain_d = gain_q - exp_dec;
          end
`else
          if (gain_ext <= (GAIN_W+1)'(RELEASE_STEP)) begin
            gain_d  = '0;
            state_d = IDLE;
          end else begin
            gain_d = gain_q - GAIN_W'(RELEASE_STEP);
          end
`endif
        end
        default: begin
          state_d = IDLE;
          gain_d  = '0;
          div_d   = '0;
        end
      endcase
    end

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge audio_tick or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gain_q      <= '0;
      div_q       <= '0;
      gate_prev_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      div_q       <= div_d;
      gate_prev_q <= gate;
      active_q    <= active_d;
    end
  end

  assign gain      = gain_q;
  assign active    = active_q;
  assign env_state = state_q;

endmodule

// File: tb/tb_adsr_envelope_generator.sv
// Directed bench for adsr_envelope_generator: vector table for the main envelope, hand sequences for corners.
module tb_adsr_envelope_generator;

  logic       audio_tick = 1'b0;
  logic       reset_n;
  logic       gate;
  logic [7:0] attack_rate, decay_rate, release_rate;
  logic [9:0] sustain_level;
  logic [9:0] gain;
  logic       active;
  logic [2:0] env_state;

  int n_cmp  = 0;
  int n_fail = 0;

  adsr_envelope_generator dut (
    .audio_tick   (audio_tick),
    .reset_n      (reset_n),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain_level(sustain_level),
    .gain         (gain),
    .active       (active),
    .env_state    (env_state)
  );

  always #5 audio_tick = ~audio_tick;

  typedef struct {
    logic g;
    int   ar, dr, rr, sus;
    int   n;
    int   eg, es, ea;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic g, int ar, int dr, int rr, int sus, int n,
                              int eg, int es, int ea);
    vec_t v;
    v.g = g; v.ar = ar; v.dr = dr; v.rr = rr; v.sus = sus; v.n = n;
    v.eg = eg; v.es = es; v.ea = ea;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge audio_tick);
    #1;
  endtask

  task automatic wait_state(int st, int budget, string name);
    int k = 0;
    while (int'(env_state) != st && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, int'(env_state), st);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int g;
    vec_t v;

    // gate, attack, decay, release, sustain, edges, gain, state, active
    vecs.push_back(mk(0, 0, 0, 0, 512,  2,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 512,  1,    0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512,  1,   32, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512, 30,  992, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512,  1, 1023, 2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512,  1, 1007, 2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512, 30,  527, 2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512,  1,  512, 3, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512,  5,  512, 3, 1));
    vecs.push_back(mk(1, 0, 0, 0, 100,  1,  100, 3, 1));
    vecs.push_back(mk(1, 0, 0, 0, 512,  1,  512, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 512,  1,  512, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 512,  1,  480, 4, 1));
`ifdef ADSR_EXP_RELEASE_EN
    vecs.push_back(mk(0, 0, 0, 0, 512,  1,  450, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 512,  1,  422, 4, 1));
`else
    vecs.push_back(mk(0, 0, 0, 0, 512, 14,   32, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 512,  1,    0, 0, 0));
`endif
    vecs.push_back(mk(0, 0, 0, 0, 512, 200,   0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 512,  1,    0, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 512,  3,    0, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 512,  1,   32, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 512,  3,   32, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 512,  1,   64, 1, 1));

    reset_n = 1'b0; gate = 1'b0;
    attack_rate = '0; decay_rate = '0; release_rate = '0; sustain_level = 10'd512;
    #12;
    chk("reset_gain",   int'(gain), 0);
    chk("reset_state",  int'(env_state), 0);
    chk("reset_active", int'(active), 0);
    $display("reset: gain=%0d state=%0d active=%0d", gain, env_state, active);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      gate = v.g;
      attack_rate = 8'(v.ar); decay_rate = 8'(v.dr); release_rate = 8'(v.rr);
      sustain_level = 10'(v.sus);
      tick(v.n);
      chk($sformatf("vec%0d_gain", i),   int'(gain), v.eg);
      chk($sformatf("vec%0d_state", i),  int'(env_state), v.es);
      chk($sformatf("vec%0d_active", i), int'(active), v.ea);
      $display("vec%0d: gate=%0d edges=%0d gain=%0d state=%0d active=%0d",
               i, v.g, v.n, gain, env_state, active);
    end

    // Retrigger from a non-zero release level: attack resumes from 400
    attack_rate = '0; decay_rate = '0; sustain_level = 10'd400;
    wait_state(3, 200, "retrig_sustain_state");
    chk("retrig_sustain_gain", int'(gain), 400);
    gate = 1'b0; tick(1);
    chk("retrig_fall_state", int'(env_state), 4);
    chk("retrig_fall_gain",  int'(gain), 400);
    gate = 1'b1; tick(1);
    chk("retrig_rise_state", int'(env_state), 1);
    chk("retrig_rise_gain",  int'(gain), 400);
    tick(1);
    chk("retrig_step_gain",  int'(gain), 432);
    $display("retrigger: gain=%0d state=%0d", gain, env_state);

    // Asynchronous reset mid-attack, then release with gate held high
    tick(2);
    chk("pre_reset_gain", int'(gain), 496);
    #3; reset_n = 1'b0; #1;
    chk("async_reset_gain",   int'(gain), 0);
    chk("async_reset_state",  int'(env_state), 0);
    chk("async_reset_active", int'(active), 0);
    #2; reset_n = 1'b1;
    tick(1);
    chk("gate_at_release_state",  int'(env_state), 1);
    chk("gate_at_release_gain",   int'(gain), 0);
    chk("gate_at_release_active", int'(active), 1);
    $display("async reset: gain=%0d state=%0d active=%0d", gain, env_state, active);

    // Full-scale release with release_rate = 1 (a step every second edge)
    sustain_level = 10'd1023;
    wait_state(3, 200, "full_sustain_state");
    chk("full_sustain_gain", int'(gain), 1023);
    release_rate = 8'd1; gate = 1'b0;
    tick(1);
    chk("rel_fall_state", int'(env_state), 4);
    chk("rel_fall_gain",  int'(gain), 1023);
    tick(1);
    chk("rel_wait_gain",  int'(gain), 1023);
    tick(1);
`ifdef ADSR_EXP_RELEASE_EN
    chk("rel_step1_gain", int'(gain), 960);
    tick(1);
    chk("rel_hold1_gain", int'(gain), 960);
    tick(1);
    chk("rel_step2_gain", int'(gain), 900);
    cnt = 0;
    while (int'(gain) > 15 && cnt < 400) begin
      tick(1);
      cnt++;
    end
    chk("exp_tail_start", int'(gain), 15);
    for (g = 14; g >= 0; g--) begin
      tick(2);
      chk($sformatf("exp_tail_%0d", g), int'(gain), g);
    end
`else
    chk("rel_step1_gain", int'(gain), 991);
    tick(1);
    chk("rel_hold1_gain", int'(gain), 991);
    tick(1);
    chk("rel_step2_gain", int'(gain), 959);
    cnt = 0;
    while (int'(env_state) != 0 && cnt < 200) begin
      tick(1);
      cnt++;
    end
    chk("lin_release_edges", cnt, 60);
    chk("lin_release_gain", int'(gain), 0);
`endif
    chk("release_end_state",  int'(env_state), 0);
    chk("release_end_active", int'(active), 0);
    $display("release: gain=%0d state=%0d active=%0d", gain, env_state, active);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adsr_envelope_generator.md
# adsr_envelope_generator

Parametrised four-stage (attack/decay/sustain/release) envelope generator, the successor to the single-stage decay envelope used by the drum voices. It is clocked by the audio sample tick and driven by a level `gate` (note held) instead of a one-shot trigger. It produces an unsigned gain word for the voice multiplier. Runtime rate and sustain inputs let one instance serve both percussive and sustained voices.

## Interface
- `GAIN_W`, 10: gain width; full scale `MAX = 2^GAIN_W - 1`.
- `RATE_W`, 8: width of the rate inputs.
- `ATTACK_STEP`, 32: gain increment per attack step.
- `DECAY_STEP`, 16: gain decrement per decay step.
- `RELEASE_STEP`, 32: gain decrement per linear release step.
- `RELEASE_SHIFT`, 4: exponential release shift; used only when the macro is defined.

- `audio_tick`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `gate`  in  1  note held; sampled on `audio_tick`.
- `attack_rate`  in  RATE_W  ticks per attack step, minus 1.
- `decay_rate`  in  RATE_W  ticks per decay step, minus 1.
- `release_rate`  in  RATE_W  ticks per release step, minus 1.
- `sustain_level`  in  GAIN_W  sustain target.
- `gain`  out  GAIN_W  registered envelope value.
- `active`  out  1  high when `env_state != IDLE`; registered.
- `env_state`  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- Edge detect uses registered `gate_d`: `rise = gate & ~gate_d`, `fall = ~gate & gate_d`.
- One divider `div` (RATE_W) is shared across stages. A "step" occurs on an edge where `div == rate` of the current stage. On a step, `div` returns to 0; otherwise `div` increments. `div` clears on every state transition.
- Priority order: reset, then rise, then fall, then step.
- Rise, from any state: go to ATTACK and clear `div`. `gain` is unchanged, so a retrigger ramps from the current value with no click. No step occurs on that edge.
- Fall, in ATTACK, DECAY or SUSTAIN: go to RELEASE and clear `div`. `gain` is held on that edge. A fall in IDLE or RELEASE is ignored.
- ATTACK step:
  - If `gain >= MAX - ATTACK_STEP`: `gain = MAX`, go to DECAY.
  - Otherwise: `gain += ATTACK_STEP`.
- DECAY step:
  - If `gain <= sustain_level + DECAY_STEP` (compare at GAIN_W+1 bits): `gain = sustain_level`, go to SUSTAIN.
  - Otherwise: `gain -= DECAY_STEP`.
- SUSTAIN: `gain = sustain_level` on every edge, so live changes take effect one edge later. `div` is held at 0.
- RELEASE step:
  - If `gain <= RELEASE_STEP`: `gain = 0`, go to IDLE.
  - Otherwise: `gain -= RELEASE_STEP`.
- IDLE: `gain` is 0 and `div` is 0.
- All arithmetic saturates; `gain` never wraps.

## Timing
- Reset values: `gain = 0`, `env_state = IDLE`, `active = 0`, `div = 0`, `gate_d = 0`. Reset takes effect immediately, including mid-envelope.
- If `gate` is high at reset release, the first edge is a rise, and `env_state = ATTACK` after that edge.
- A rise or fall sampled at edge N updates `env_state` and `active` after edge N.
- After a transition at edge N, the first step lands at edge `N + rate + 1`; steps then repeat every `rate + 1` edges. `rate = 0` gives a step on every edge.
- Full attack from 0 with defaults takes 32 steps: 31 × (+32) reaches 992, then the 32nd step clamps to 1023.
- Rate inputs are read live each edge. A change mid-stage applies at the next `div == rate` compare; if the new rate is below `div`, `div` runs on and wraps at `2^RATE_W`.

## Configuration
- `ADSR_EXP_RELEASE_EN` defined: exponential release.
  - RELEASE step: `gain -= max(gain >> RELEASE_SHIFT, 1)`.
  - On reaching 0, go to IDLE.
  - `RELEASE_STEP` is unused.
- `ADSR_EXP_RELEASE_EN` undefined: linear release as specified in Operation.

## Test plan
- Reset with `gate = 0`: `gain = 0`, `env_state = 0`, `active = 0`. Assert `reset_n` low mid-ATTACK → `gain = 0` immediately, without waiting for an edge.
- `gate` rises, all rates 0, `sustain_level = 512`, defaults:
  - ATTACK, reaching 1023 at the 32nd edge after the rise edge.
  - DECAY reaches 512 after 32 more steps (1023 − 31×16 = 527 ≤ 528 → 512), then SUSTAIN.
  - `gate` falls → 16 release steps (512 − 15×32 = 32 → 0), then IDLE, `active = 0`.
- `attack_rate = 3`: `gain` is 32 on the 4th edge after the rise and 64 on the 8th.
- Retrigger: drop `gate` in RELEASE at `gain = 400`, re-raise it → ATTACK from 400, next step gives 432.
- In SUSTAIN, change `sustain_level` 512 → 100 → `gain = 100` one edge later, state stays SUSTAIN.
- With `ADSR_EXP_RELEASE_EN`: release from 1023 gives 960, then 900; tail decrements by 1 from 15 down to 0, then IDLE.
